// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared constants, types and round-robin pick function for ram_arbiter
package ram_arbiter_pkg;

   localparam int MAX_MASTERS = 8;

   typedef struct packed {
      int   idx;
      logic vld;
   } rr_pick_t;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // First requester at or after ptr, wrapping modulo n.
   function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req, input int ptr, input int n);
      rr_pick_t res;
      int       k;
      res.idx = 0;
      res.vld = 1'b0;
      for (int i = 0; i < MAX_MASTERS; i++) begin
         if (i < n && !res.vld) begin
            k = ptr + i;
            if (k >= n) k = k - n;
            if (req[k]) begin
               res.idx = k;
               res.vld = 1'b1;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_rr_arb.sv
// rtl/ram_rr_arb.sv - round-robin arbiter with internal priority pointer
module ram_rr_arb
   import ram_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   localparam int IDX_W = idx_width(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] req,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic [IDX_W-1:0]       gnt_idx,
   output logic                   gnt_vld
);

   logic [IDX_W-1:0] rr_ptr;
   rr_pick_t         pick;

   always_comb begin
      pick    = rr_pick(MAX_MASTERS'(req), int'(rr_ptr), NUM_MASTERS);
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      if (!rst && pick.vld) begin
         gnt_vld      = 1'b1;
         gnt_idx      = IDX_W'(pick.idx);
         gnt[gnt_idx] = 1'b1;
      end
   end

   // The winner drops to lowest priority; no grant leaves the pointer alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (gnt_vld) begin
         rr_ptr <= (int'(gnt_idx) == NUM_MASTERS - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin sharing of one single-port synchronous RAM between masters
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int dat_width   = 32,
   parameter int adr_width   = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_MASTERS-1:0]           req_i,
   input  logic [NUM_MASTERS-1:0]           we_i,
   input  logic [NUM_MASTERS*adr_width-1:0] addr_i,
   input  logic [NUM_MASTERS*dat_width-1:0] wdata_i,
   output logic [NUM_MASTERS-1:0]           ack_o,
   output logic [NUM_MASTERS-1:0]           resp_o,
   output logic [dat_width-1:0]             rdata_o,
   output logic [adr_width-1:0]             ram_adr_o,
   output logic                             ram_we_o,
   output logic [dat_width-1:0]             ram_dat_o,
   input  logic [dat_width-1:0]             ram_dat_i
);

   localparam int IDX_W = idx_width(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] gnt;
   logic [IDX_W-1:0]       gnt_idx;
   logic                   gnt_vld;
   logic                   rd_pend;
   logic [IDX_W-1:0]       rd_owner;
   logic                   rd_issue;

   ram_rr_arb #(
      .NUM_MASTERS(NUM_MASTERS)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_i),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign ack_o    = gnt;
   assign rd_issue = gnt_vld && !(|(we_i & gnt));

   // Grant is one-hot, so at most one master's fields reach the RAM pins.
   always_comb begin
      ram_adr_o = '0;
      ram_dat_o = '0;
      ram_we_o  = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (gnt[k]) begin
            ram_adr_o = addr_i[k*adr_width +: adr_width];
            ram_dat_o = wdata_i[k*dat_width +: dat_width];
            ram_we_o  = we_i[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend  <= 1'b0;
         rd_owner <= '0;
      end else begin
         rd_pend <= rd_issue;
         if (rd_issue) rd_owner <= gnt_idx;
      end
   end

   always_comb begin
      resp_o = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         resp_o[k] = rd_pend && (rd_owner == IDX_W'(k));
      end
   end

   assign rdata_o = ram_dat_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with 2- and 4-master instances
module tb_ram_arbiter;

   logic clk;
   logic rst;

   logic [1:0]  req2, we2, ack2, resp2;
   logic [63:0] addr2, wdata2;
   logic [31:0] rdata2, ram_adr2, ram_dout2, ram_din2;
   logic        ram_we2;

   logic [3:0]   req4, we4, ack4, resp4;
   logic [127:0] addr4, wdata4;
   logic [31:0]  rdata4, ram_adr4, ram_dout4, ram_din4;
   logic         ram_we4;

   int tests = 0;
   int fails = 0;

   ram_arbiter #(.NUM_MASTERS(2), .dat_width(32), .adr_width(32)) u2 (
      .clk(clk), .rst(rst), .req_i(req2), .we_i(we2), .addr_i(addr2), .wdata_i(wdata2),
      .ack_o(ack2), .resp_o(resp2), .rdata_o(rdata2), .ram_adr_o(ram_adr2),
      .ram_we_o(ram_we2), .ram_dat_o(ram_dout2), .ram_dat_i(ram_din2)
   );

   ram_arbiter #(.NUM_MASTERS(4), .dat_width(32), .adr_width(32)) u4 (
      .clk(clk), .rst(rst), .req_i(req4), .we_i(we4), .addr_i(addr4), .wdata_i(wdata4),
      .ack_o(ack4), .resp_o(resp4), .rdata_o(rdata4), .ram_adr_o(ram_adr4),
      .ram_we_o(ram_we4), .ram_dat_o(ram_dout4), .ram_dat_i(ram_din4)
   );

   // RAM models: read-first, 1-cycle registered read; unwritten words read as A000_00xx.
   logic [31:0] mem2 [256];
   bit          wr2  [256];
   logic [31:0] mem4 [256];
   bit          wr4  [256];

   always @(posedge clk) begin
      ram_din2 <= wr2[ram_adr2[7:0]] ? mem2[ram_adr2[7:0]] : (32'hA000_0000 | {24'h0, ram_adr2[7:0]});
      if (ram_we2) begin
         mem2[ram_adr2[7:0]] <= ram_dout2;
         wr2[ram_adr2[7:0]]  <= 1'b1;
      end
      ram_din4 <= wr4[ram_adr4[7:0]] ? mem4[ram_adr4[7:0]] : (32'hA000_0000 | {24'h0, ram_adr4[7:0]});
      if (ram_we4) begin
         mem4[ram_adr4[7:0]] <= ram_dout4;
         wr4[ram_adr4[7:0]]  <= 1'b1;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rst_late;
      logic [1:0]  req;
      logic [1:0]  we;
      logic [7:0]  a0;
      logic [7:0]  a1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  ack;
      logic        ram_we;
      logic [7:0]  adr;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   function automatic vec_t mk(logic r, logic rl, logic [1:0] rq, logic [1:0] w,
                               logic [7:0] a0, logic [7:0] a1, logic [31:0] d0, logic [31:0] d1,
                               logic [1:0] ack, logic rwe, logic [7:0] adr,
                               logic [1:0] resp, logic [31:0] rd);
      vec_t v;
      v.rst = r; v.rst_late = rl; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1;
      v.d0 = d0; v.d1 = d1; v.ack = ack; v.ram_we = rwe; v.adr = adr;
      v.resp = resp; v.rdata = rd;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s row %0d: got %h required %h", name, row, got, exp);
      end
   endtask

   vec_t tbl[21];
   int   exp_g[14];

   initial begin
      //            rst rl  req    we     a0     a1     d0          d1            ack    rwe  adr    resp   rdata
      tbl[0]  = mk(1, 0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,      32'h0,        2'b00, 0, 8'h00, 2'b00, 32'h0);
      tbl[1]  = mk(1, 0, 2'b11, 2'b11, 8'h05, 8'h06, 32'h1,      32'h2,        2'b00, 0, 8'h00, 2'b00, 32'h0);
      tbl[2]  = mk(0, 1, 2'b01, 2'b00, 8'h10, 8'h00, 32'h0,      32'h0,        2'b01, 0, 8'h10, 2'b00, 32'h0);
      tbl[3]  = mk(1, 0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,      32'h0,        2'b00, 0, 8'h00, 2'b00, 32'h0);
      tbl[4]  = mk(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,      32'h0,        2'b00, 0, 8'h00, 2'b00, 32'h0);
      tbl[5]  = mk(0, 0, 2'b10, 2'b10, 8'h00, 8'h04, 32'h0,      32'hDEADBEEF, 2'b10, 1, 8'h04, 2'b00, 32'h0);
      tbl[6]  = mk(0, 0, 2'b10, 2'b00, 8'h00, 8'h04, 32'h0,      32'h0,        2'b10, 0, 8'h04, 2'b00, 32'h0);
      tbl[7]  = mk(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,      32'h0,        2'b00, 0, 8'h00, 2'b10, 32'hDEADBEEF);
      tbl[8]  = mk(0, 0, 2'b11, 2'b00, 8'h00, 8'h01, 32'h0,      32'h0,        2'b01, 0, 8'h00, 2'b00, 32'h0);
      tbl[9]  = mk(0, 0, 2'b11, 2'b00, 8'h00, 8'h01, 32'h0,      32'h0,        2'b10, 0, 8'h01, 2'b01, 32'hA0000000);
      tbl[10] = mk(0, 0, 2'b11, 2'b00, 8'h00, 8'h01, 32'h0,      32'h0,        2'b01, 0, 8'h00, 2'b10, 32'hA0000001);
      tbl[11] = mk(0, 0, 2'b11, 2'b00, 8'h00, 8'h01, 32'h0,      32'h0,        2'b10, 0, 8'h01, 2'b01, 32'hA0000000);
      tbl[12] = mk(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,      32'h0,        2'b00, 0, 8'h00, 2'b10, 32'hA0000001);
      tbl[13] = mk(0, 0, 2'b11, 2'b01, 8'h08, 8'h08, 32'h11,     32'h0,        2'b01, 1, 8'h08, 2'b00, 32'h0);
      tbl[14] = mk(0, 0, 2'b10, 2'b00, 8'h00, 8'h08, 32'h0,      32'h0,        2'b10, 0, 8'h08, 2'b00, 32'h0);
      tbl[15] = mk(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,      32'h0,        2'b00, 0, 8'h00, 2'b10, 32'h11);
      tbl[16] = mk(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,      32'h0,        2'b00, 0, 8'h00, 2'b00, 32'h0);
      tbl[17] = mk(0, 0, 2'b10, 2'b10, 8'h00, 8'h20, 32'h0,      32'h55,       2'b10, 1, 8'h20, 2'b00, 32'h0);
      tbl[18] = mk(0, 0, 2'b11, 2'b00, 8'h20, 8'h03, 32'h0,      32'h0,        2'b01, 0, 8'h20, 2'b00, 32'h0);
      tbl[19] = mk(0, 0, 2'b10, 2'b00, 8'h00, 8'h03, 32'h0,      32'h0,        2'b10, 0, 8'h03, 2'b01, 32'h55);
      tbl[20] = mk(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0,      32'h0,        2'b00, 0, 8'h00, 2'b10, 32'hA0000003);

      exp_g = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3, 0, 1, 3};

      rst = 1'b1;
      req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
      req4 = '0; we4 = '0; wdata4 = '0;
      addr4 = {32'd3, 32'd2, 32'd1, 32'd0};
      @(posedge clk);

      for (int i = 0; i < 21; i++) begin
         #1;
         rst    = tbl[i].rst;
         req2   = tbl[i].req;
         we2    = tbl[i].we;
         addr2  = {24'h0, tbl[i].a1, 24'h0, tbl[i].a0};
         wdata2 = {tbl[i].d1, tbl[i].d0};
         #4;
         chk("ack", i, 64'(ack2), 64'(tbl[i].ack));
         chk("ram_we", i, 64'(ram_we2), 64'(tbl[i].ram_we));
         chk("ram_adr", i, 64'(ram_adr2), 64'({24'h0, tbl[i].adr}));
         chk("resp", i, 64'(resp2), 64'(tbl[i].resp));
         if (tbl[i].ram_we)
            chk("ram_dat", i, 64'(ram_dout2), 64'(tbl[i].ack[1] ? tbl[i].d1 : tbl[i].d0));
         if (tbl[i].resp != 2'b00)
            chk("rdata", i, 64'(rdata2), 64'(tbl[i].rdata));
         if (i == 0) chk("ack4_rst", i, 64'(ack4), 64'(0));
         if (tbl[i].rst_late) rst = 1'b1;
         @(posedge clk);
      end

      // Four-master fairness: full rotation, then req[2] withdrawn.
      for (int c = 0; c < 15; c++) begin
         #1;
         req2 = '0;
         req4 = (c < 8) ? 4'b1111 : ((c < 14) ? 4'b1011 : 4'b0000);
         #4;
         if (c < 14) chk("fair_ack", c, 64'(ack4), 64'(4'b0001 << exp_g[c]));
         else        chk("fair_ack_idle", c, 64'(ack4), 64'(0));
         if (c > 0) begin
            chk("fair_resp", c, 64'(resp4), 64'(4'b0001 << exp_g[c-1]));
            chk("fair_rdata", c, 64'(rdata4), 64'(32'hA0000000 | 32'(exp_g[c-1])));
         end else begin
            chk("fair_resp0", c, 64'(resp4), 64'(0));
         end
         @(posedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin arbiter sharing one single-port synchronous RAM (1-cycle registered read, read-first, no byte enables) between NUM_MASTERS requesters.
- Each master uses a req/ack/resp handshake. Read data returns one cycle after ack, with resp routed to the issuing master only.
- Sits between CPU/DMA-side masters and the RAM macro; drives the RAM's address, write-enable and write-data pins directly.

Parameters:
- NUM_MASTERS, 2, number of requesters; legal range 2..8.
- dat_width, 32, data width; must equal the RAM's data width.
- adr_width, 32, address width; must equal the RAM's address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_i  input  NUM_MASTERS  per-master access request.
- we_i  input  NUM_MASTERS  per-master write flag; 1 = write, 0 = read.
- addr_i  input  NUM_MASTERS*adr_width  packed per-master addresses; master k occupies bits [k*adr_width +: adr_width].
- wdata_i  input  NUM_MASTERS*dat_width  packed per-master write data.
- ack_o  output  NUM_MASTERS  one-hot grant; combinational, asserted in the cycle the access is issued to the RAM.
- resp_o  output  NUM_MASTERS  one-hot read-data-valid; registered.
- rdata_o  output  dat_width  read data, broadcast to all masters; valid only where resp_o is high.
- ram_adr_o  output  adr_width  to RAM adr_i.
- ram_we_o  output  1  to RAM we_i.
- ram_dat_o  output  dat_width  to RAM dat_i.
- ram_dat_i  input  dat_width  from RAM dat_o.

Behaviour:
- State:
  - rr_ptr: index of the highest-priority master.
  - rd_pend: 1 bit; a read is in flight.
  - rd_owner: index of the master that issued the in-flight read.
- Reset (synchronous):
  - rr_ptr=0, rd_pend=0, rd_owner=0.
  - While rst=1: ack_o=0, ram_we_o=0, ram_adr_o=0, ram_dat_o=0.
  - resp_o=0 from the first edge with rst=1. An in-flight read is discarded and no resp is issued for it after reset.
- Arbitration (combinational, rst=0):
  - Winner g = first k with req_i[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
  - ack_o = one-hot(g); ram_adr_o = addr_i[g]; ram_dat_o = wdata_i[g]; ram_we_o = we_i[g].
  - No requests: ack_o=0, ram_we_o=0, ram_adr_o=0, ram_dat_o=0.
- Pointer update:
  - On a grant, rr_ptr <= (g+1) mod NUM_MASTERS.
  - No grant: rr_ptr holds.
  - A lone requester is granted every cycle.
- Read response:
  - On a read grant, rd_pend <= 1 and rd_owner <= g; otherwise rd_pend <= 0.
  - resp_o is a registered decode: resp_o[k] = rd_pend && rd_owner==k.
  - rdata_o = ram_dat_i, passed through combinationally. It is valid in the cycle resp_o is high, i.e. exactly 1 cycle after ack.
  - When resp_o=0, rdata_o is don't-care; the bench must not check it.
- Writes: committed at the edge ending the ack cycle; no resp is generated.
- Pipelining:
  - Back-to-back grants are allowed every cycle, including read-after-write to the same address.
  - Read-after-write returns the new data because the RAM write completes before the next read samples.
  - A read in the same cycle as another master's write is impossible, since there is a single port.
- Master protocol:
  - A master holds req/we/addr/wdata stable until it sees ack.
  - req may drop without ack; there is no penalty and no state change.
- Throughput: 1 access per cycle total. Starvation-free: a waiting master is granted within NUM_MASTERS cycles.

Decomposition:
- Package ram_arbiter_pkg holds:
  - constant IDX_W = clog2(NUM_MASTERS), minimum 1;
  - function rr_pick(req, ptr), returning winner index plus a valid flag.
- One sub-module, ram_rr_arb: req vector and rst in, rr_ptr register inside; outputs one-hot grant, grant index and valid. Reused by future shared-resource blocks.
- Datapath muxing and response tracking stay in ram_arbiter.

Test Plan:
- Reset mid-read: master 0 reads 0x10, rst=1 on the next edge -> resp_o stays 0; after release, rr_ptr=0 and all outputs are 0.
- Single master:
  - Master 1 writes 0xDEADBEEF to 0x4 -> ack_o=2'b10 in the same cycle.
  - Next cycle it reads 0x4 -> ack_o=2'b10, then one cycle later resp_o=2'b10 with rdata_o=0xDEADBEEF.
- Contention: both request reads of 0x0 and 0x1 continuously after reset -> acks alternate 01,10,01,10; each resp_o is 1 cycle after its ack, with the matching data.
- Mixed pipeline: master 0 writes 0x8=0x11, master 1 reads 0x8 in the following grant -> resp_o=2'b10 with rdata_o=0x11.
- Fairness at NUM_MASTERS=4: all req high for 8 cycles -> grants 0,1,2,3,0,1,2,3. Dropping req[2] -> grants skip index 2 with no idle cycle.
- Idle: req_i=0 -> ram_we_o=0, ack_o=0, rr_ptr unchanged; the next single request is granted immediately.
